// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the program sequencer: instruction word layout,
// the HALT opcode and the sequencer state encoding.
package instr_sequencer_pkg;

   localparam int INSTR_W = 11;
   localparam int OPC_MSB = 10;
   localparam int OPC_LSB = 8;
   localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

   localparam logic [OPC_W-1:0] OPC_HLT = 3'b111;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_LOAD    = 3'd2,
      ST_ISSUE   = 3'd3,
      ST_ADVANCE = 3'd4,
      ST_HALTED  = 3'd5
   } seq_state_t;

   function automatic logic is_halt(input logic [INSTR_W-1:0] word);
      return word[OPC_MSB:OPC_LSB] == OPC_HLT;
   endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Program-ROM read port plus the instruction issue port towards the decoder.
// master = sequencer side, slave = ROM/decoder side.
interface instr_sequencer_if #(
   parameter int PC_W = 4
) ();
   import instr_sequencer_pkg::*;

   logic [PC_W-1:0]    pm_addr;
   logic               pm_en;
   logic [INSTR_W-1:0] pm_data;
   logic [INSTR_W-1:0] instr;
   logic               instr_valid;

   modport master (
      output pm_addr,
      output pm_en,
      input  pm_data,
      output instr,
      output instr_valid
   );

   modport slave (
      input  pm_addr,
      input  pm_en,
      output pm_data,
      input  instr,
      input  instr_valid
   );

endinterface

// File: rtl/instr_sequencer.sv
// Program sequencer: fetches ROM words and holds each on the decoder port for
// INSTR_CYCLES cycles. Optional breakpoint support under SEQ_BREAKPOINT_EN.
module instr_sequencer
   import instr_sequencer_pkg::*;
#(
   parameter int PC_W         = 4,
   parameter int INSTR_CYCLES = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            run,
   input  logic            step,
   input  logic            restart,
   input  logic [PC_W-1:0] prog_last,
`ifdef SEQ_BREAKPOINT_EN
   input  logic            brk_en,
   input  logic [PC_W-1:0] brk_addr,
   output logic            brk_hit,
`endif
   instr_sequencer_if.master bus,
   output logic [PC_W-1:0] pc,
   output logic            busy,
   output logic            halted,
   output logic            done
);

   localparam int PH_W = (INSTR_CYCLES > 1) ? $clog2(INSTR_CYCLES) : 1;
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(INSTR_CYCLES - 1);

   seq_state_t         state_reg, state_next;
   logic [PC_W-1:0]    pc_reg, pc_next;
   logic [PH_W-1:0]    phase_reg, phase_next;
   logic               step_flag_reg, step_flag_next;
   logic [INSTR_W-1:0] instr_reg, instr_next;
   logic               done_reg, done_next;
`ifdef SEQ_BREAKPOINT_EN
   // brk_block_reg gates resumption on run until run is seen low or a step is taken.
   logic               brk_hit_reg, brk_hit_next;
   logic               brk_block_reg, brk_block_next;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         pc_reg        <= '0;
         phase_reg     <= '0;
         step_flag_reg <= 1'b0;
         instr_reg     <= '0;
         done_reg      <= 1'b0;
`ifdef SEQ_BREAKPOINT_EN
         brk_hit_reg   <= 1'b0;
         brk_block_reg <= 1'b0;
`endif
      end else begin
         state_reg     <= state_next;
         pc_reg        <= pc_next;
         phase_reg     <= phase_next;
         step_flag_reg <= step_flag_next;
         instr_reg     <= instr_next;
         done_reg      <= done_next;
`ifdef SEQ_BREAKPOINT_EN
         brk_hit_reg   <= brk_hit_next;
         brk_block_reg <= brk_block_next;
`endif
      end
   end

   always_comb begin
      state_next     = state_reg;
      pc_next        = pc_reg;
      phase_next     = phase_reg;
      step_flag_next = step_flag_reg;
      instr_next     = instr_reg;
      done_next      = 1'b0;
`ifdef SEQ_BREAKPOINT_EN
      brk_hit_next   = brk_hit_reg;
      brk_block_next = brk_block_reg;
`endif

      case (state_reg)
         ST_IDLE: begin
`ifdef SEQ_BREAKPOINT_EN
            if (!run) begin
               brk_block_next = 1'b0;
            end
            if (run && !brk_block_reg) begin
               state_next     = ST_FETCH;
               step_flag_next = 1'b0;
               brk_hit_next   = 1'b0;
            end else if (step && !run) begin
               state_next     = ST_FETCH;
               step_flag_next = 1'b1;
               brk_hit_next   = 1'b0;
               brk_block_next = 1'b0;
            end
`else
            // run wins over a simultaneous step
            if (run) begin
               state_next     = ST_FETCH;
               step_flag_next = 1'b0;
            end else if (step) begin
               state_next     = ST_FETCH;
               step_flag_next = 1'b1;
            end
`endif
         end

         ST_FETCH: begin
            state_next = ST_LOAD;
         end

         ST_LOAD: begin
            // A HALT word is never issued; pc stays on it.
            if (is_halt(bus.pm_data)) begin
               state_next = ST_HALTED;
            end else begin
               instr_next = bus.pm_data;
               phase_next = '0;
               state_next = ST_ISSUE;
            end
         end

         ST_ISSUE: begin
            if (phase_reg == PH_LAST) begin
               state_next = ST_ADVANCE;
            end else begin
               phase_next = phase_reg + 1'b1;
            end
         end

         ST_ADVANCE: begin
            if (pc_reg == prog_last) begin
               pc_next   = '0;
               done_next = 1'b1;
            end else begin
               pc_next = pc_reg + 1'b1;
            end
            step_flag_next = 1'b0;
            if (run && !step_flag_reg) begin
               state_next = ST_FETCH;
            end else begin
               state_next = ST_IDLE;
            end
`ifdef SEQ_BREAKPOINT_EN
            if (brk_en && (pc_next == brk_addr)) begin
               state_next     = ST_IDLE;
               brk_hit_next   = 1'b1;
               brk_block_next = 1'b1;
            end
`endif
         end

         ST_HALTED: begin
            if (restart) begin
               state_next = ST_IDLE;
               pc_next    = '0;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign bus.pm_addr     = pc_reg;
   assign bus.pm_en       = (state_reg == ST_FETCH);
   assign bus.instr       = instr_reg;
   assign bus.instr_valid = (state_reg == ST_ISSUE);

   assign pc     = pc_reg;
   assign busy   = (state_reg != ST_IDLE) && (state_reg != ST_HALTED);
   assign halted = (state_reg == ST_HALTED);
   assign done   = done_reg;
`ifdef SEQ_BREAKPOINT_EN
   assign brk_hit = brk_hit_reg;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: behavioural 16x11 sync ROM, a
// scoreboard of expected issued words, and one task per scenario.
module tb_instr_sequencer;
   import instr_sequencer_pkg::*;

   logic       clk;
   logic       rst;
   logic       run;
   logic       step;
   logic       restart;
   logic [3:0] prog_last;
   logic [3:0] pc;
   logic       busy;
   logic       halted;
   logic       done;

   instr_sequencer_if #(.PC_W(4)) bus ();

   instr_sequencer #(.PC_W(4), .INSTR_CYCLES(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .step      (step),
      .restart   (restart),
      .prog_last (prog_last),
      .bus       (bus),
      .pc        (pc),
      .busy      (busy),
      .halted    (halted),
      .done      (done)
   );

   logic [INSTR_W-1:0] rom [16];
   logic [INSTR_W-1:0] sb [$];
   int                 issue_cycles [$];
   int                 issue_cnt = 0;
   int                 cyc = 0;
   int                 total = 0;
   int                 passed = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
      end
   end

   always @(posedge clk) begin
      if (bus.pm_en) bus.pm_data <= rom[bus.pm_addr];
   end

   // Issue monitor: pops the scoreboard at the start of each issue window,
   // checks the word stays stable and that the window lasts three cycles.
   initial begin
      logic               prev_valid;
      int                 vlen;
      logic [INSTR_W-1:0] held;
      logic [INSTR_W-1:0] exp_word;
      prev_valid = 1'b0;
      vlen = 0;
      held = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            vlen = 0;
         end else if (bus.instr_valid) begin
            if (!prev_valid) begin
               issue_cnt = issue_cnt + 1;
               issue_cycles.push_back(cyc);
               total = total + 1;
               if (sb.size() == 0) begin
                  $display("FAIL issue_unexpected instr=%h pc=%0d", bus.instr, pc);
               end else begin
                  exp_word = sb.pop_front();
                  if (bus.instr !== exp_word)
                     $display("FAIL issue_word got=%h expected=%h", bus.instr, exp_word);
                  else
                     passed = passed + 1;
               end
               held = bus.instr;
               vlen = 1;
            end else begin
               vlen = vlen + 1;
               total = total + 1;
               if (bus.instr !== held)
                  $display("FAIL instr_stable got=%h expected=%h", bus.instr, held);
               else
                  passed = passed + 1;
            end
         end else if (prev_valid) begin
            total = total + 1;
            if (vlen != 3)
               $display("FAIL valid_len got=%0d expected=3", vlen);
            else
               passed = passed + 1;
         end
         prev_valid = bus.instr_valid && !rst;
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      run = 1'b0;
      step = 1'b0;
      restart = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic wait_idle(input int max_cycles, input string tag);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < max_cycles; i++) begin
         if (!busy) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (!ok) begin
         total = total + 1;
         $display("FAIL %s_idle_timeout busy=%b expected=0", tag, busy);
      end
   endtask

   task automatic check_sb_empty(input string tag);
      total = total + 1;
      if (sb.size() != 0)
         $display("FAIL %s_sb_left got=%0d expected=0", tag, sb.size());
      else
         passed = passed + 1;
      sb.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      run = 1'b1;
      step = 1'b0;
      restart = 1'b0;
      prog_last = 4'd2;
      tick();
      tick();
      total = total + 8;
      if (bus.pm_addr !== 4'd0) $display("FAIL rst_pm_addr got=%0d expected=0", bus.pm_addr); else passed++;
      if (bus.pm_en !== 1'b0) $display("FAIL rst_pm_en got=%b expected=0", bus.pm_en); else passed++;
      if (bus.instr !== 11'd0) $display("FAIL rst_instr got=%h expected=0", bus.instr); else passed++;
      if (bus.instr_valid !== 1'b0) $display("FAIL rst_instr_valid got=%b expected=0", bus.instr_valid); else passed++;
      if (pc !== 4'd0) $display("FAIL rst_pc got=%0d expected=0", pc); else passed++;
      if (busy !== 1'b0) $display("FAIL rst_busy got=%b expected=0", busy); else passed++;
      if (halted !== 1'b0) $display("FAIL rst_halted got=%b expected=0", halted); else passed++;
      if (done !== 1'b0) $display("FAIL rst_done got=%b expected=0", done); else passed++;
      $display("test_reset: outputs checked under reset");
      run = 1'b0;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_run_program();
      bit ok;
      int base;
      do_reset();
      prog_last = 4'd2;
      issue_cycles.delete();
      base = issue_cnt;
      sb.push_back(rom[0]);
      sb.push_back(rom[1]);
      sb.push_back(rom[2]);
      sb.push_back(rom[0]);
      run = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
      total = total + 1;
      if (!ok) $display("FAIL run_done_timeout done=%b expected=1", done); else passed++;
      total = total + 2;
      if (pc !== 4'd0) $display("FAIL run_pc_at_done got=%0d expected=0", pc); else passed++;
      if (issue_cnt - base != 3) $display("FAIL run_issues_at_done got=%0d expected=3", issue_cnt - base); else passed++;
      tick();
      total = total + 1;
      if (done !== 1'b0) $display("FAIL run_done_pulse got=%b expected=0", done); else passed++;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (issue_cnt - base == 4) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      total = total + 1;
      if (!ok) $display("FAIL run_restart_timeout got=%0d expected=4", issue_cnt - base); else passed++;
      run = 1'b0;
      wait_idle(20, "run");
      total = total + 1;
      if (pc !== 4'd1) $display("FAIL run_pc_after_stop got=%0d expected=1", pc); else passed++;
      for (int i = 1; i < issue_cycles.size(); i++) begin
         total = total + 1;
         if (issue_cycles[i] - issue_cycles[i-1] != 6)
            $display("FAIL run_spacing got=%0d expected=6", issue_cycles[i] - issue_cycles[i-1]);
         else
            passed++;
      end
      check_sb_empty("run");
      $display("test_run_program: %0d issues, pc=%0d", issue_cnt - base, pc);
   endtask

   task automatic test_step();
      int base;
      do_reset();
      prog_last = 4'd7;
      base = issue_cnt;
      for (int k = 0; k < 3; k++) begin
         sb.push_back(rom[k]);
         step = 1'b1;
         tick();
         step = 1'b0;
         if (k == 0) begin
            tick();
            step = 1'b1;
            tick();
            step = 1'b0;
         end
         wait_idle(20, "step");
         tick();
         tick();
         total = total + 3;
         if (pc !== 4'(k + 1)) $display("FAIL step_pc got=%0d expected=%0d", pc, k + 1); else passed++;
         if (issue_cnt - base != k + 1) $display("FAIL step_count got=%0d expected=%0d", issue_cnt - base, k + 1); else passed++;
         if (busy !== 1'b0) $display("FAIL step_busy got=%b expected=0", busy); else passed++;
         $display("test_step: step %0d pc=%0d", k, pc);
      end
      check_sb_empty("step");
   endtask

   task automatic test_halt();
      bit ok;
      int base;
      logic [INSTR_W-1:0] saved;
      do_reset();
      saved = rom[1];
      rom[1] = 11'b111_0000_0000;
      prog_last = 4'd5;
      base = issue_cnt;
      sb.push_back(rom[0]);
      run = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (halted) begin
            ok = 1'b1;
            break;
         end
      end
      total = total + 1;
      if (!ok) $display("FAIL halt_timeout halted=%b expected=1", halted); else passed++;
      total = total + 4;
      if (pc !== 4'd1) $display("FAIL halt_pc got=%0d expected=1", pc); else passed++;
      if (busy !== 1'b0) $display("FAIL halt_busy got=%b expected=0", busy); else passed++;
      if (issue_cnt - base != 1) $display("FAIL halt_issued got=%0d expected=1", issue_cnt - base); else passed++;
      if (bus.instr !== rom[0]) $display("FAIL halt_instr_hold got=%h expected=%h", bus.instr, rom[0]); else passed++;
      step = 1'b1;
      tick();
      step = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      total = total + 2;
      if (halted !== 1'b1) $display("FAIL halt_sticky got=%b expected=1", halted); else passed++;
      if (pc !== 4'd1) $display("FAIL halt_pc_sticky got=%0d expected=1", pc); else passed++;
      run = 1'b0;
      restart = 1'b1;
      tick();
      restart = 1'b0;
      total = total + 3;
      if (halted !== 1'b0) $display("FAIL restart_halted got=%b expected=0", halted); else passed++;
      if (pc !== 4'd0) $display("FAIL restart_pc got=%0d expected=0", pc); else passed++;
      if (busy !== 1'b0) $display("FAIL restart_busy got=%b expected=0", busy); else passed++;
      rom[1] = saved;
      check_sb_empty("halt");
      $display("test_halt: halted at pc=1, restart to pc=%0d", pc);
   endtask

   task automatic test_drop_run();
      bit ok;
      int base;
      do_reset();
      prog_last = 4'd7;
      base = issue_cnt;
      for (int k = 0; k < 5; k++) sb.push_back(rom[k]);
      run = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (bus.instr_valid && pc == 4'd4) begin
            ok = 1'b1;
            break;
         end
      end
      total = total + 1;
      if (!ok) $display("FAIL drop_timeout pc=%0d expected=4", pc); else passed++;
      run = 1'b0;
      wait_idle(20, "drop");
      total = total + 2;
      if (pc !== 4'd5) $display("FAIL drop_pc got=%0d expected=5", pc); else passed++;
      if (issue_cnt - base != 5) $display("FAIL drop_count got=%0d expected=5", issue_cnt - base); else passed++;
      check_sb_empty("drop");
      $display("test_drop_run: stopped at pc=%0d", pc);
   endtask

   task automatic test_rst_mid();
      bit ok;
      do_reset();
      prog_last = 4'd7;
      for (int k = 0; k < 3; k++) sb.push_back(rom[k]);
      run = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.instr_valid && pc == 4'd2) begin
            ok = 1'b1;
            break;
         end
      end
      total = total + 1;
      if (!ok) $display("FAIL rstmid_timeout pc=%0d expected=2", pc); else passed++;
      #2;
      rst = 1'b1;
      run = 1'b0;
      #1;
      total = total + 5;
      if (bus.instr_valid !== 1'b0) $display("FAIL rstmid_valid got=%b expected=0", bus.instr_valid); else passed++;
      if (bus.instr !== 11'd0) $display("FAIL rstmid_instr got=%h expected=0", bus.instr); else passed++;
      if (pc !== 4'd0) $display("FAIL rstmid_pc got=%0d expected=0", pc); else passed++;
      if (busy !== 1'b0) $display("FAIL rstmid_busy got=%b expected=0", busy); else passed++;
      if (bus.pm_en !== 1'b0) $display("FAIL rstmid_pm_en got=%b expected=0", bus.pm_en); else passed++;
      tick();
      rst = 1'b0;
      tick();
      sb.push_back(rom[0]);
      run = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.instr_valid) begin
            ok = 1'b1;
            break;
         end
      end
      total = total + 2;
      if (!ok) $display("FAIL rstmid_rerun_timeout valid=%b expected=1", bus.instr_valid); else passed++;
      if (pc !== 4'd0) $display("FAIL rstmid_rerun_pc got=%0d expected=0", pc); else passed++;
      run = 1'b0;
      wait_idle(20, "rstmid");
      total = total + 1;
      if (pc !== 4'd1) $display("FAIL rstmid_final_pc got=%0d expected=1", pc); else passed++;
      check_sb_empty("rstmid");
      $display("test_rst_mid: restarted from pc=0, now pc=%0d", pc);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) rom[i] = {3'(i % 7), 4'(i), 4'(15 - i)};
      rst = 1'b1;
      run = 1'b0;
      step = 1'b0;
      restart = 1'b0;
      prog_last = 4'd0;
      test_reset();
      test_run_program();
      test_step();
      test_halt();
      test_drop_run();
      test_rst_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout time=%0t limit=200000", $time);
      $fatal(1, "timeout");
   end

endmodule
